serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. Two WIDTH-bit operands and a carry-in are
// accepted in one cycle, then added one bit per cycle, LSB first, through a
// single full adder. The result is held until the consumer takes it.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high. Input side: in_valid_i/in_ready_o (ready only in IDLE).
// Output side: out_valid_o/out_ready_i (valid only in DONE). Inputs are
// ignored whenever the matching ready/valid from this block is low.
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds overflow_o, the
// two's-complement overflow flag of the addition.
//
// Parameters
//   WIDTH        operand width in bits, 2..64
//
// Ports
//   clk_i        clock, all state updates on rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand request valid
//   in_ready_o   controller can accept operands (IDLE)
//   a_i, b_i     operands
//   cin_i        initial carry
//   out_valid_o  result available (DONE)
//   out_ready_i  consumer accepts the result
//   sum_o        result bits (partial shift contents during RUN)
//   cout_o       final carry
//   busy_o       serial addition in progress (RUN)
//   overflow_o   two's-complement overflow (only with SERIAL_ADD_OVF_EN)
// -----------------------------------------------------------------------------

// One-bit full adder; the only adder datapath in the controller.
module serial_add_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Current FSM state; kept as a named enum so checkers can bind to it.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;
    logic last_bit;

    serial_add_full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    // The counter never reaches WIDTH: the last bit edge leaves RUN instead
    // of incrementing, so a power-of-two WIDTH cannot wrap.
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sum_d   = '0;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Sum bits enter at the MSB; after WIDTH shifts bit 0 of the
                // result sits at sum_q[0].
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                if (last_bit) begin
                    state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this edge.
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == RUN);
    assign sum_o       = sum_q;
    // carry_q holds the final carry once DONE is reached and is left untouched
    // until the next accept.
    assign cout_o      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign overflow_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl at WIDTH=8, followed by a randomized
// back-to-back run checked against a+b+cin through an expected queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_add_ctrl;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .busy_o      (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .overflow_o  (ovf)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'd0);
        check({tag, "_cout"}, 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
    endtask

    // Accept one operand set and wait for DONE; result is left pending.
    task automatic start_and_wait(input string tag, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic cv);
        int cyc;
        check({tag, "_ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        step();
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd8);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout;
        int           cyc;
        int           issued;
        int           results;
        logic [W:0]   exp_v;

        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check_reset_outputs("post_reset");

        // 0x3C + 0x05 + 0 = 0x041
        start_and_wait("op1", 8'h3C, 8'h05, 1'b0);
        check("op1_sum", 64'(sum), 64'h41);
        check("op1_cout", 64'(cout), 64'd0);
        release_result("op1");

        // 0xFF + 0x00 + 1 = 0x100
        start_and_wait("op2", 8'hFF, 8'h00, 1'b1);
        check("op2_sum", 64'(sum), 64'h00);
        check("op2_cout", 64'(cout), 64'd1);
`ifdef SERIAL_ADD_OVF_EN
        check("op2_ovf", 64'(ovf), 64'd0);
`endif
        release_result("op2");

        // 0x7F + 0x01 + 0 = 0x080, signed overflow
        start_and_wait("op3", 8'h7F, 8'h01, 1'b0);
        check("op3_sum", 64'(sum), 64'h80);
        check("op3_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("op3_ovf", 64'(ovf), 64'd1);
`endif
        release_result("op3");

        // 0xA5 + 0x5A + 1 = 0x100
        start_and_wait("op4", 8'hA5, 8'h5A, 1'b1);
        check("op4_sum", 64'(sum), 64'h00);
        check("op4_cout", 64'(cout), 64'd1);

        // Stall in DONE for 5 cycles while disturbing the request side.
        held_sum  = 8'h00;
        held_cout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = W'($urandom_range(0, 255));
            cin = ~cin;
            step();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_ready", 64'(in_ready), 64'd0);
            check("stall_sum", 64'(sum), 64'(held_sum));
            check("stall_cout", 64'(cout), 64'(held_cout));
        end
        in_valid = 1'b0;
        release_result("stall");

        // Reset between edges while processing bit 4.
        start_and_wait("op5", 8'h3C, 8'h05, 1'b0);
        release_result("op5");
        in_valid = 1'b1;
        a = 8'h3C;
        b = 8'hC3;
        cin = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #3;
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) cyc++;
        end
        check("no_stale_valid", 64'(cyc), 64'd0);
        start_and_wait("op6", 8'h01, 8'h01, 1'b0);
        check("op6_sum", 64'(sum), 64'h02);
        check("op6_cout", 64'(cout), 64'd0);
        release_result("op6");

        // Randomized back-to-back traffic with consumer stalls.
        issued  = 0;
        results = 0;
        cyc     = 0;
        while ((issued < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            in_valid  = (issued < 1000);
            a         = W'($urandom_range(0, 255));
            b         = W'($urandom_range(0, 255));
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
                issued++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_result", 64'({cout, sum}), 64'(exp_v));
                end
                results++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_issued", 64'(issued), 64'd1000);
        check("rand_results", 64'(results), 64'd1000);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
